adder100_sched: RTL and testbench
=================================

# adder100_sched

Round-robin scheduler that shares a single Adder100 carry-lookahead instance between two requesters. Each requester issues 100-bit add operations over a valid/ready handshake. The block arbitrates, drives the shared adder, and holds the result in a one-entry output register tagged with the requester ID until it is consumed. It sits between the operand producers and the shared adder datapath, so two clients can use one wide adder without duplicating it.

## Interface

**Parameters**
- `WIDTH`, default 100: operand width. Fixed at 100 to match the Adder100 instance; other values are unsupported.

**Ports**
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle when high with `req0_valid`.
- `req0_a`  in  WIDTH  requester 0 operand A.
- `req0_b`  in  WIDTH  requester 0 operand B.
- `req0_cin`  in  1  requester 0 carry-in.
- `req0_chain`  in  1  requester 0 uses its stored carry instead of `req0_cin` (only with macro).
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`, `req1_chain`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  result register holds a result.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_sum`  out  WIDTH  registered sum.
- `rsp_cout`  out  1  registered carry-out.
- `rsp_id`  out  1  requester that issued the result.

## Operation

- **Output register slot:** one entry, `full` = `rsp_valid`.
- **Issue condition:** `can_issue` = `!rsp_valid || rsp_ready`.
- **Arbitration:**
  - One grant per cycle, and only when `can_issue` is high.
  - If only one request is valid, that requester is granted.
  - If both are valid, the requester not granted last wins.
  - `last_grant` resets to 1, so requester 0 wins the first contention.
  - `last_grant` updates on every grant.
- **Ready signals:** `reqN_ready` = `can_issue && grant==N`. Ready is combinational from the valids and `rsp_valid`/`rsp_ready`. Ready never depends on `reqN_ready` of the other port.
- **Datapath:**
  - The granted requester's a, b and effective cin are muxed into the Adder100 instance.
  - The adder outputs are captured into `rsp_sum`/`rsp_cout`, and `rsp_id` captures the grant.
  - The adder is combinational, with no internal state.
- **Result register transitions:**
  - EMPTY to FULL on a grant.
  - FULL stays FULL when `rsp_ready` and a grant occur in the same cycle: the register reloads with the new result.
  - FULL to EMPTY on `rsp_ready` with no grant.
  - FULL holds, with sum/cout/id stable, while `rsp_ready` is low.
- **Arithmetic:** `{rsp_cout, rsp_sum}` = a + b + cin_eff, exact to 101 bits, no saturation; wrap-around appears as `rsp_cout`=1.
- **Reset:**
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_id`=0, `last_grant`=1, carry registers=0.
  - Both readies are 0 during the reset cycle.
  - A held result is discarded, and an in-flight handshake in the reset cycle is not accepted.

## Timing

- Latency is one cycle: accept at edge T, `rsp_valid` high after edge T.
- Sustained throughput is one operation per cycle when `rsp_ready` is held high.
- Back-to-back results from alternating requesters are allowed.
- A requester must hold its operands stable while valid and not ready.
- The consumer sees results in grant order.

## Configuration

- Macro: `ADDER_SCHED_CHAIN_EN`.
- **Defined:**
  - Each requester N has a carry register `creg[N]`, reset to 0.
  - On a grant to N, cin_eff = `reqN_chain ? creg[N] : reqN_cin`.
  - On that same grant, `creg[N]` <= adder cout.
  - `creg[N]` is unchanged by grants to the other requester.
  - This allows multi-word (200-bit, 300-bit, ...) additions issued least-significant word first.
- **Undefined:**
  - cin_eff = `reqN_cin`, `reqN_chain` is ignored, and no carry registers are built.
  - Port list is identical in both builds.

## Test plan

- **Basic add:** after reset, req0 a=1, b=1, cin=0, `rsp_ready`=1 -> `req0_ready` same cycle; next cycle `rsp_valid`=1, sum=2, cout=0, id=0.
- **Overflow:** req1 a=all ones, b=0, cin=1 -> sum=0, cout=1, id=1.
- **Contention:** both valid continuously for 4 cycles with `rsp_ready`=1 -> ids in order 0,1,0,1, one result per cycle.
- **Backpressure:** result FULL with `rsp_ready`=0 for 3 cycles -> both readies 0, `rsp_sum`/`rsp_id` stable. Raising `rsp_ready` -> the result is consumed and the next grant loads in the same cycle.
- **Chain (with `ADDER_SCHED_CHAIN_EN`):** req0 a=all ones, b=0, cin=1, chain=0 (gives cout=1), then req0 a=0, b=0, cin=0, chain=1 -> sum=1, cout=0. Without the macro the second operation gives sum=0.
- **Reset mid-operation:** assert `reset` while `rsp_valid`=1 and req0 is valid -> next cycle `rsp_valid`=0, readies 0 during reset. First contention after reset grants req0.

Source files
------------

// File: rtl/adder100_sched.sv
// adder100_sched: round-robin sharing of one Adder100 carry-lookahead adder between two requesters,
// with a one-entry tagged result register. Define ADDER_SCHED_CHAIN_EN to build per-requester carry chaining.

// Pure combinational 100-bit adder: 4-bit lookahead groups, group carries rippled between groups.
module Adder100 (
  input  logic [99:0] a_i,
  input  logic [99:0] b_i,
  input  logic        cin_i,
  output logic [99:0] sum_o,
  output logic        cout_o
);
  localparam int GROUPS = 25;

  logic [99:0]     gen;
  logic [99:0]     prop;
  logic [99:0]     carry;
  logic [GROUPS:0] groupCarry;

  assign gen           = a_i & b_i;
  assign prop          = a_i ^ b_i;
  assign groupCarry[0] = cin_i;

  for (genvar k = 0; k < GROUPS; k++) begin : gen_group
    logic [3:0] gg;
    logic [3:0] pp;
    logic       ci;

    assign gg = gen[4*k +: 4];
    assign pp = prop[4*k +: 4];
    assign ci = groupCarry[k];

    assign carry[4*k]   = ci;
    assign carry[4*k+1] = gg[0] | (pp[0] & ci);
    assign carry[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    assign carry[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                        | (pp[2] & pp[1] & pp[0] & ci);
    assign groupCarry[k+1] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                           | (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & ci);
  end

  assign sum_o  = prop ^ carry;
  assign cout_o = groupCarry[GROUPS];
endmodule

module adder100_sched #(
  parameter int WIDTH = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req0_chain,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  input  logic             req1_chain,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);
  typedef enum logic {EMPTY, FULL} slotState_t;

  slotState_t       slot_q, slot_d;
  logic             lastGrant_q;
  logic             canIssue;
  logic             grantValid;
  logic             grantId;
  logic [WIDTH-1:0] selA, selB;
  logic             cinEff;
  logic [WIDTH-1:0] addSum;
  logic             addCout;

  // Grants are suppressed during reset so no handshake completes in that cycle.
  assign canIssue   = (slot_q == EMPTY) || rsp_ready;
  assign grantValid = !reset && canIssue && (req0_valid || req1_valid);
  assign grantId    = (req0_valid && req1_valid) ? !lastGrant_q : req1_valid;
  assign req0_ready = grantValid && !grantId;
  assign req1_ready = grantValid && grantId;

  assign selA = grantId ? req1_a : req0_a;
  assign selB = grantId ? req1_b : req0_b;

`ifdef ADDER_SCHED_CHAIN_EN
  logic [1:0] creg_q;

  always_comb begin
    cinEff = grantId ? req1_cin : req0_cin;
    if (grantId ? req1_chain : req0_chain) cinEff = creg_q[grantId];
  end

  always_ff @(posedge clk) begin
    if (reset)           creg_q          <= '0;
    else if (grantValid) creg_q[grantId] <= addCout;
  end
`else
  logic unusedChain;
  assign unusedChain = req0_chain ^ req1_chain;
  assign cinEff      = grantId ? req1_cin : req0_cin;
`endif

  Adder100 u_adder (
    .a_i   (selA),
    .b_i   (selB),
    .cin_i (cinEff),
    .sum_o (addSum),
    .cout_o(addCout)
  );

  always_ff @(posedge clk) begin
    if (reset) slot_q <= EMPTY;
    else       slot_q <= slot_d;
  end

  always_comb begin
    slot_d = slot_q;
    if (grantValid)     slot_d = FULL;
    else if (rsp_ready) slot_d = EMPTY;
  end

  always_comb begin
    rsp_valid = (slot_q == FULL);
  end

  // Result payload only moves on a grant, so it stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_sum     <= '0;
      rsp_cout    <= 1'b0;
      rsp_id      <= 1'b0;
      lastGrant_q <= 1'b1;
    end else if (grantValid) begin
      rsp_sum     <= addSum;
      rsp_cout    <= addCout;
      rsp_id      <= grantId;
      lastGrant_q <= grantId;
    end
  end
endmodule

// File: tb/tb_adder100_sched.sv
// tb_adder100_sched: directed plan scenarios plus randomized traffic, checked against a
// behavioural model built from plain 101-bit arithmetic and round-robin rules.
module tb_adder100_sched;
  localparam int W = 100;
  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] ZERO = '0;
  localparam logic [W-1:0] ONE  = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req0_ready, req0_cin = 1'b0, req0_chain = 1'b0;
  logic         req1_valid = 1'b0, req1_ready, req1_cin = 1'b0, req1_chain = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_cout, rsp_id;
  logic [W-1:0] rsp_sum;

  int compareCount = 0;
  int mismatchCount = 0;

  // Model of what the consumer should see after each edge.
  logic         mValid = 1'b0, mCout = 1'b0, mId = 1'b0, mLast = 1'b1;
  logic [W-1:0] mSum = '0;
  logic         mGrant0, mGrant1;
`ifdef ADDER_SCHED_CHAIN_EN
  logic         mCreg [2] = '{1'b0, 1'b0};
`endif

  logic         pV [2];
  logic         pCin [2];
  logic         pCh [2];
  logic [W-1:0] pA [2];
  logic [W-1:0] pB [2];

  always #5 clk = ~clk;

  adder100_sched #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_chain(req0_chain),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_chain(req1_chain),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [W-1:0] rand100();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return ONES;
      1:       return ZERO;
      default: return t[W-1:0];
    endcase
  endfunction

  // One clock of stimulus: readies checked before the edge, result register after it.
  task automatic applyStimulus(input logic rst,
                               input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic cin0, input logic ch0,
                               input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input logic cin1, input logic ch1, input logic rr);
    logic         doGrant, gid, cinEff;
    logic [W:0]   total;
    @(negedge clk);
    reset = rst;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = cin0; req0_chain = ch0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = cin1; req1_chain = ch1;
    rsp_ready = rr;
    #2;
    doGrant = !rst && (!mValid || rr) && (v0 || v1);
    gid     = (v0 && v1) ? !mLast : v1;
    mGrant0 = doGrant && !gid;
    mGrant1 = doGrant && gid;
    checkOutput("req0Ready", {127'b0, req0_ready}, {127'b0, mGrant0});
    checkOutput("req1Ready", {127'b0, req1_ready}, {127'b0, mGrant1});
    @(posedge clk);
    #1;
    if (rst) begin
      mValid = 1'b0; mSum = '0; mCout = 1'b0; mId = 1'b0; mLast = 1'b1;
`ifdef ADDER_SCHED_CHAIN_EN
      mCreg[0] = 1'b0; mCreg[1] = 1'b0;
`endif
    end else if (doGrant) begin
      cinEff = gid ? cin1 : cin0;
`ifdef ADDER_SCHED_CHAIN_EN
      if (gid ? ch1 : ch0) cinEff = mCreg[gid];
`endif
      total = {1'b0, (gid ? a1 : a0)} + {1'b0, (gid ? b1 : b0)} + (W+1)'(cinEff);
      mSum = total[W-1:0]; mCout = total[W]; mId = gid; mLast = gid; mValid = 1'b1;
`ifdef ADDER_SCHED_CHAIN_EN
      mCreg[gid] = total[W];
`endif
    end else if (rr) begin
      mValid = 1'b0;
    end
    checkOutput("rspValid", {127'b0, rsp_valid}, {127'b0, mValid});
    checkOutput("rspSum", {28'b0, rsp_sum}, {28'b0, mSum});
    checkOutput("rspCout", {127'b0, rsp_cout}, {127'b0, mCout});
    checkOutput("rspId", {127'b0, rsp_id}, {127'b0, mId});
  endtask

  initial begin
    logic [W-1:0] chainExp;

    applyStimulus(1, 0, ZERO, ZERO, 0, 0, 0, ZERO, ZERO, 0, 0, 1);
    applyStimulus(1, 1, ONE, ONE, 0, 0, 1, ONE, ONE, 0, 0, 1);
    checkOutput("resetValid", {127'b0, rsp_valid}, 128'd0);

    // Basic add and overflow.
    applyStimulus(0, 1, ONE, ONE, 0, 0, 0, ZERO, ZERO, 0, 0, 1);
    checkOutput("basicSum", {28'b0, rsp_sum}, 128'd2);
    checkOutput("basicId", {127'b0, rsp_id}, 128'd0);
    applyStimulus(0, 0, ZERO, ZERO, 0, 0, 1, ONES, ZERO, 1, 0, 1);
    checkOutput("ovfSum", {28'b0, rsp_sum}, 128'd0);
    checkOutput("ovfCout", {127'b0, rsp_cout}, 128'd1);
    checkOutput("ovfId", {127'b0, rsp_id}, 128'd1);

    // Contention straight after reset alternates starting with requester 0.
    applyStimulus(1, 0, ZERO, ZERO, 0, 0, 0, ZERO, ZERO, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, W'(k), ONE, 0, 0, 1, W'(k + 10), ONE, 0, 0, 1);
      checkOutput("contId", {127'b0, rsp_id}, 128'(k % 2));
      checkOutput("contValid", {127'b0, rsp_valid}, 128'd1);
    end

    // Backpressure: held result stays put, then reload on release.
    applyStimulus(0, 1, W'(5), W'(7), 0, 0, 0, ZERO, ZERO, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, W'(3), W'(3), 0, 0, 1, W'(9), W'(9), 1, 0, 0);
      checkOutput("bpSum", {28'b0, rsp_sum}, 128'd12);
      checkOutput("bpId", {127'b0, rsp_id}, 128'd0);
    end
    applyStimulus(0, 1, W'(3), W'(3), 0, 0, 1, W'(9), W'(9), 1, 0, 1);
    checkOutput("bpReloadSum", {28'b0, rsp_sum}, 128'd19);
    checkOutput("bpReloadId", {127'b0, rsp_id}, 128'd1);

    // Two-word chained add.
    applyStimulus(0, 1, ONES, ZERO, 1, 0, 0, ZERO, ZERO, 0, 0, 1);
    applyStimulus(0, 1, ZERO, ZERO, 0, 1, 0, ZERO, ZERO, 0, 0, 1);
`ifdef ADDER_SCHED_CHAIN_EN
    chainExp = ONE;
`else
    chainExp = ZERO;
`endif
    checkOutput("chainSum", {28'b0, rsp_sum}, {28'b0, chainExp});

    // Reset while a result is held and requests are pending.
    applyStimulus(1, 1, ONE, ONE, 0, 0, 1, ONE, ONE, 0, 0, 1);
    checkOutput("midResetValid", {127'b0, rsp_valid}, 128'd0);
    applyStimulus(0, 1, ONE, ONE, 0, 0, 1, ONE, ONE, 0, 0, 1);
    checkOutput("postResetId", {127'b0, rsp_id}, 128'd0);

    // Randomized traffic; operands held until the model says accepted.
    for (int i = 0; i < 2; i++) pV[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pV[i] && $urandom_range(0, 3) != 0) begin
          pV[i] = 1'b1; pA[i] = rand100(); pB[i] = rand100();
          pCin[i] = 1'($urandom); pCh[i] = 1'($urandom);
        end
      end
      applyStimulus(($urandom_range(0, 63) == 0), pV[0], pA[0], pB[0], pCin[0], pCh[0],
                    pV[1], pA[1], pB[1], pCin[1], pCh[1], ($urandom_range(0, 3) != 0));
      if (mGrant0) pV[0] = 1'b0;
      if (mGrant1) pV[1] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end
endmodule
